strange_seq: RTL and testbench

- Parametrised step sequencer; successor to the fixed 4-state `strange` FSM.
- Walks an index from S0 towards a terminal state S(N-1) under a 2-bit step command.
- Dwells a programmable number of cycles in the terminal state, returns to S0 and pulses `done`.
- Sits in the lab's logic-system exercise designs as the reusable sequencer; with default parameters it is cycle-equivalent to `strange`.

---
 rtl/strange_seq_pkg.sv | 35 +++
 rtl/strange_seq_enc.sv | 28 ++
 rtl/strange_seq.sv | 101 ++++++++++
 tb/tb_strange_seq.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/strange_seq_pkg.sv
// Shared step-code constants and the saturating next-index function for strange_seq.
// next_idx is evaluated in 32-bit integer arithmetic and clamped to LAST before callers truncate it.
package strange_seq_pkg;

    typedef logic [1:0] step_t;

    localparam step_t STEP_HOLD  = 2'd0;
    localparam step_t STEP_INC   = 2'd1;
    localparam step_t STEP_ALIGN = 2'd2;
    localparam step_t STEP_JUMP  = 2'd3;

    function automatic int next_idx(
        input int    idx,
        input step_t s,
        input int    nstates,
        input int    align,
        input int    jump
    );
        int last;
        int nxt;
        last = nstates - 1;
        case (s)
            STEP_INC:   nxt = idx + 1;
            // An already-aligned index still advances a full granule.
            STEP_ALIGN: nxt = ((idx / align) + 1) * align;
            STEP_JUMP:  nxt = idx + jump;
            default:    nxt = idx;
        endcase
        if (nxt > last) begin
            nxt = last;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/strange_seq_enc.sv
// Combinational idx -> state encoder; the one place the state encoding is chosen.
// ONEHOT=1 gives an NSTATES-wide one-hot vector, otherwise the binary index passes through.
module strange_seq_enc
    import strange_seq_pkg::*;
#(
    parameter int NSTATES = 4,
    parameter int ONEHOT  = 0,
    parameter int IW      = 2,
    parameter int SW      = 2
) (
    input  logic [IW-1:0] idx,
    output logic [SW-1:0] state
);

    generate
        if (ONEHOT != 0) begin : g_onehot
            always_comb begin
                state = '0;
                for (int i = 0; i < SW; i++) begin
                    state[i] = (idx == IW'(i));
                end
            end
        end else begin : g_binary
            assign state = SW'(idx);
        end
    endgenerate

endmodule

// File: rtl/strange_seq.sv
// Parametrised step sequencer: walks idx from S0 to LAST, dwells DWELL cycles, wraps and pulses done.
// With default parameters it reproduces the fixed 4-state strange FSM cycle for cycle.
module strange_seq
    import strange_seq_pkg::*;
#(
    parameter int NSTATES = 4,
    parameter int ALIGN   = 2,
    parameter int JUMP    = 2,
    parameter int DWELL   = 1,
    parameter int ONEHOT  = 0,
    localparam int IW     = (NSTATES > 2) ? $clog2(NSTATES) : 1,
    localparam int SW     = (ONEHOT != 0) ? NSTATES : IW
) (
    input  logic          clk,
    input  logic          res_n,
    input  logic          clr,
    input  logic [1:0]    s,
    output logic [SW-1:0] state,
    output logic [IW-1:0] idx,
    output logic          at_last,
    output logic          done
);

    localparam int LAST = NSTATES - 1;
    localparam int CW   = (DWELL > 1) ? $clog2(DWELL + 1) : 1;

    generate
        if (NSTATES < 2) begin : g_bad_nstates
            $error("strange_seq: NSTATES must be at least 2");
        end
        if (ALIGN < 1) begin : g_bad_align
            $error("strange_seq: ALIGN must be at least 1");
        end
        if (JUMP < 1) begin : g_bad_jump
            $error("strange_seq: JUMP must be at least 1");
        end
        if (DWELL < 1) begin : g_bad_dwell
            $error("strange_seq: DWELL must be at least 1");
        end
        if (ONEHOT != 0 && ONEHOT != 1) begin : g_bad_onehot
            $error("strange_seq: ONEHOT must be 0 or 1");
        end
    endgenerate

    logic [IW-1:0] idx_q;
    logic [IW-1:0] idx_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          done_q;
    logic          done_d;

    assign at_last = (idx_q == IW'(LAST));

    // cnt_q holds the number of dwell cycles already completed; the current one is cnt_q+1.
    always_comb begin
        idx_d  = idx_q;
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (clr) begin
            idx_d = '0;
            cnt_d = '0;
        end else if (at_last) begin
            if (cnt_q == CW'(DWELL - 1)) begin
                idx_d  = '0;
                cnt_d  = '0;
                done_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            idx_d = IW'(next_idx(int'(idx_q), s, NSTATES, ALIGN, JUMP));
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            idx_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign idx  = idx_q;
    assign done = done_q;

    strange_seq_enc #(
        .NSTATES (NSTATES),
        .ONEHOT  (ONEHOT),
        .IW      (IW),
        .SW      (SW)
    ) u_enc (
        .idx   (idx_q),
        .state (state)
    );

endmodule

// File: tb/tb_strange_seq.sv
// Bench for strange_seq: four parameterisations share one clock, each driven independently.
// Expected {done, at_last, idx} words are queued when a step is driven and popped after the edge.
module tb_strange_seq;

    logic       clk = 1'b0;
    logic       rst_a [4];
    logic       clr_a [4];
    logic [1:0] s_a   [4];

    logic [1:0] idx0;  logic [1:0] st0;  logic last0;  logic done0;
    logic [1:0] idx1;  logic [3:0] st1;  logic last1;  logic done1;
    logic [2:0] idx2;  logic [2:0] st2;  logic last2;  logic done2;
    logic [2:0] idx3;  logic [2:0] st3;  logic last3;  logic done3;

    int total = 0;
    int bad   = 0;
    logic [4:0] exp_q[$];

    int s_tab [25] = '{0,1,0,1,0,1,0,0, 2,3,0, 3,3,0, 1,3,0, 1,2,2,0, 1,1,1,3};
    int i_tab [25] = '{0,1,1,2,2,3,0,0, 2,3,0, 2,3,0, 1,3,0, 1,2,3,0, 1,2,3,0};
    int d_tab [25] = '{0,0,0,0,0,0,1,0, 0,0,1, 0,0,1, 0,0,1, 0,0,0,1, 0,0,0,1};

    always #5 clk = ~clk;

    strange_seq u_def (
        .clk(clk), .res_n(rst_a[0]), .clr(clr_a[0]), .s(s_a[0]),
        .state(st0), .idx(idx0), .at_last(last0), .done(done0)
    );

    strange_seq #(.ONEHOT(1)) u_oh (
        .clk(clk), .res_n(rst_a[1]), .clr(clr_a[1]), .s(s_a[1]),
        .state(st1), .idx(idx1), .at_last(last1), .done(done1)
    );

    strange_seq #(.NSTATES(8), .ALIGN(4), .JUMP(3), .DWELL(3)) u_big (
        .clk(clk), .res_n(rst_a[2]), .clr(clr_a[2]), .s(s_a[2]),
        .state(st2), .idx(idx2), .at_last(last2), .done(done2)
    );

    strange_seq #(.NSTATES(5)) u_five (
        .clk(clk), .res_n(rst_a[3]), .clr(clr_a[3]), .s(s_a[3]),
        .state(st3), .idx(idx3), .at_last(last3), .done(done3)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [2:0] last_of(input int d);
        case (d)
            2:       return 3'd7;
            3:       return 3'd4;
            default: return 3'd3;
        endcase
    endfunction

    task automatic check_out(input int d);
        logic [4:0] e;
        logic [2:0] oi;
        logic [7:0] os;
        logic [7:0] es;
        logic       ol;
        logic       od;
        if (exp_q.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
            return;
        end
        e = exp_q.pop_front();
        case (d)
            0:       begin oi = {1'b0, idx0}; os = {6'b0, st0}; ol = last0; od = done0; end
            1:       begin oi = {1'b0, idx1}; os = {4'b0, st1}; ol = last1; od = done1; end
            2:       begin oi = idx2;         os = {5'b0, st2}; ol = last2; od = done2; end
            default: begin oi = idx3;         os = {5'b0, st3}; ol = last3; od = done3; end
        endcase
        es = (d == 1) ? (8'd1 << e[2:0]) : {5'b0, e[2:0]};
        chk($sformatf("d%0d idx", d), 32'(oi), 32'(e[2:0]));
        chk($sformatf("d%0d state", d), 32'(os), 32'(es));
        chk($sformatf("d%0d at_last", d), 32'(ol), 32'(e[3]));
        chk($sformatf("d%0d done", d), 32'(od), 32'(e[4]));
    endtask

    task automatic step(input int d, input int sv, input logic cv, input int ei, input logic ed);
        logic [2:0] e_idx;
        e_idx = 3'(ei);
        s_a[d]   = 2'(sv);
        clr_a[d] = cv;
        exp_q.push_back({ed, (e_idx == last_of(d)), e_idx});
        @(posedge clk);
        #1;
        s_a[d]   = 2'd0;
        clr_a[d] = 1'b0;
        check_out(d);
    endtask

    task automatic reset_check(input int d);
        exp_q.push_back(5'b0);
        check_out(d);
    endtask

    initial begin
        for (int d = 0; d < 4; d++) begin
            rst_a[d] = 1'b0;
            clr_a[d] = 1'b0;
            s_a[d]   = 2'd0;
        end
        repeat (10) @(posedge clk);
        #1;
        for (int d = 0; d < 4; d++) reset_check(d);
        @(negedge clk);
        for (int d = 0; d < 4; d++) rst_a[d] = 1'b1;

        // strange transition map, binary and one-hot
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 25; i++) step(d, s_tab[i], 1'b0, i_tab[i], d_tab[i][0]);
        end

        // NSTATES=8 ALIGN=4 JUMP=3 DWELL=3: align walk, dwell, jump saturation
        step(2, 2, 0, 4, 0); step(2, 2, 0, 7, 0);
        step(2, 0, 0, 7, 0); step(2, 0, 0, 7, 0);
        step(2, 0, 0, 0, 1); step(2, 0, 0, 0, 0);
        step(2, 3, 0, 3, 0); step(2, 3, 0, 6, 0); step(2, 3, 0, 7, 0);
        step(2, 1, 0, 7, 0); step(2, 3, 0, 7, 0); step(2, 0, 0, 0, 1);
        // clr beats s mid-walk
        step(2, 3, 0, 3, 0); step(2, 3, 1, 0, 0);
        // clr on dwell cycle 2
        step(2, 3, 0, 3, 0); step(2, 3, 0, 6, 0); step(2, 3, 0, 7, 0);
        step(2, 0, 0, 7, 0); step(2, 0, 1, 0, 0); step(2, 0, 0, 0, 0);
        // clr on the natural wrap edge; full dwell proves the counter was cleared
        step(2, 3, 0, 3, 0); step(2, 3, 0, 6, 0); step(2, 3, 0, 7, 0);
        step(2, 0, 0, 7, 0); step(2, 0, 0, 7, 0); step(2, 0, 1, 0, 0);
        step(2, 0, 0, 0, 0);

        // NSTATES=5: clamp of jump and align at LAST=4
        step(3, 3, 0, 2, 0); step(3, 1, 0, 3, 0); step(3, 3, 0, 4, 0); step(3, 0, 0, 0, 1);
        step(3, 1, 0, 1, 0); step(3, 2, 0, 2, 0); step(3, 2, 0, 4, 0); step(3, 2, 0, 0, 1);
        step(3, 1, 0, 1, 0); step(3, 1, 0, 2, 0); step(3, 1, 0, 3, 0); step(3, 2, 0, 4, 0);
        step(3, 0, 0, 0, 1);

        // asynchronous reset mid-walk on the default instance
        step(0, 1, 0, 1, 0); step(0, 1, 0, 2, 0);
        #2;
        rst_a[0] = 1'b0;
        #1;
        reset_check(0);
        @(negedge clk);
        rst_a[0] = 1'b1;
        step(0, 1, 0, 1, 0);

        // asynchronous reset mid-dwell clears the dwell counter and suppresses done
        step(2, 3, 0, 3, 0); step(2, 3, 0, 6, 0); step(2, 3, 0, 7, 0);
        #2;
        rst_a[2] = 1'b0;
        #1;
        reset_check(2);
        @(negedge clk);
        rst_a[2] = 1'b1;
        step(2, 0, 0, 0, 0);
        step(2, 3, 0, 3, 0); step(2, 3, 0, 6, 0); step(2, 3, 0, 7, 0);
        step(2, 0, 0, 7, 0); step(2, 0, 0, 7, 0); step(2, 0, 0, 0, 1);

        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
